// File: rtl/branch_seq_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_pkg                                                       |
// | Shared branch func3 codes, sequencer states and legality helper. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        REDIR = 2'd2
    } state_t;

    // 010 and 011 are the only encodings with no branch meaning
    function automatic logic func3_legal(input logic [2:0] func3);
        return (func3 != 3'b010) && (func3 != 3'b011);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_seq_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_seq_ctrl_if                                               |
// | Decode request, resolution status and fetch redirect bundle.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface branch_seq_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_func3;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_imm;
    logic            res_valid;
    logic            res_taken;
    logic            misalign;
    logic            illegal;
    logic            redir_valid;
    logic            redir_ready;
    logic [XLEN-1:0] redir_pc;
    logic            flush;

    modport master (
        output req_valid, req_func3, req_rs1, req_rs2, req_pc, req_imm, redir_ready,
        input  req_ready, res_valid, res_taken, misalign, illegal,
               redir_valid, redir_pc, flush
    );

    modport slave (
        input  req_valid, req_func3, req_rs1, req_rs2, req_pc, req_imm, redir_ready,
        output req_ready, res_valid, res_taken, misalign, illegal,
               redir_valid, redir_pc, flush
    );
endinterface
`default_nettype wire

// File: rtl/branch_seq_ctrl_compare.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_compare                                                   |
// | Combinational branch condition: eq / signed lt / unsigned lt.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module branch_compare
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_func3,
    output logic            o_cond
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (i_rs1 == i_rs2);
    assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
    assign w_ltu = (i_rs1 < i_rs2);

    always_comb begin
        o_cond = 1'b0;
        case (i_func3)
            F3_BEQ:  o_cond = w_eq;
            F3_BNE:  o_cond = !w_eq;
            F3_BLT:  o_cond = w_lt;
            F3_BGE:  o_cond = !w_lt;
            F3_BLTU: o_cond = w_ltu;
            F3_BGEU: o_cond = !w_ltu;
            default: o_cond = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_seq_ctrl                                                  |
// | Branch resolution sequencer: capture, evaluate, redirect fetch.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module branch_seq_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_seq_ctrl_if.slave   bus,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   resolved_cnt,
    output logic [CNT_W-1:0]   taken_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [2:0]      r_func3;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_redir_pc;
    logic            r_req_ready;
    logic            r_redir_valid;
    logic [CNT_W-1:0] r_resolved_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic            w_cond;
    logic            w_legal;
    logic            w_eval;
    logic            w_resolve;
    logic            w_taken;
    logic            w_aligned;
    logic [XLEN-1:0] w_target;

    branch_compare #(
        .XLEN (XLEN)
    ) u_compare (
        .i_rs1   (r_rs1),
        .i_rs2   (r_rs2),
        .i_func3 (r_func3),
        .o_cond  (w_cond)
    );

    assign w_eval    = (r_state == EVAL);
    assign w_legal   = func3_legal(r_func3);
    assign w_resolve = w_eval && w_legal;
    assign w_taken   = w_resolve && w_cond;
    assign w_target  = r_pc + r_imm;
    assign w_aligned = (w_target[1:0] == 2'b00);

    assign bus.req_ready   = r_req_ready;
    assign bus.res_valid   = w_resolve;
    assign bus.res_taken   = w_taken;
    assign bus.misalign    = w_taken && !w_aligned;
    assign bus.illegal     = w_eval && !w_legal;
    assign bus.redir_valid = r_redir_valid;
    assign bus.redir_pc    = r_redir_pc;
    assign bus.flush       = r_redir_valid && bus.redir_ready;

    assign resolved_cnt = r_resolved_cnt;
    assign taken_cnt    = r_taken_cnt;

    // req_ready is registered so it tracks the state with no path from req_*
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_func3       <= 3'b000;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_pc          <= '0;
            r_imm         <= '0;
            r_redir_pc    <= '0;
            r_req_ready   <= 1'b0;
            r_redir_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (bus.req_valid && r_req_ready) begin
                        r_func3     <= bus.req_func3;
                        r_rs1       <= bus.req_rs1;
                        r_rs2       <= bus.req_rs2;
                        r_pc        <= bus.req_pc;
                        r_imm       <= bus.req_imm;
                        r_req_ready <= 1'b0;
                        r_state     <= EVAL;
                    end
                end
                EVAL: begin
                    if (w_taken && w_aligned) begin
                        r_redir_pc    <= w_target;
                        r_redir_valid <= 1'b1;
                        r_state       <= REDIR;
                    end else begin
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                REDIR: begin
                    if (bus.redir_ready) begin
                        r_redir_valid <= 1'b0;
                        r_req_ready   <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_redir_valid <= 1'b0;
                    r_req_ready   <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resolved_cnt <= '0;
            r_taken_cnt    <= '0;
        end else if (clr_cnt) begin
            r_resolved_cnt <= '0;
            r_taken_cnt    <= '0;
        end else begin
            if (w_resolve) begin
                r_resolved_cnt <= r_resolved_cnt + c_cnt_one;
            end
            if (w_taken) begin
                r_taken_cnt <= r_taken_cnt + c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_branch_seq_ctrl                                               |
// | Scoreboard bench: driver pushes expectations, monitor compares.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_branch_seq_ctrl;
    import branch_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    typedef struct {
        logic             illegal;
        logic             taken;
        logic             mis;
        int               eval_cyc;
        logic [CNT_W-1:0] rc;
        logic [CNT_W-1:0] tc;
    } res_t;

    typedef struct {
        logic [XLEN-1:0] pc;
        int              first_cyc;
    } rd_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr_cnt = 1'b0;
    logic [CNT_W-1:0] resolved_cnt;
    logic [CNT_W-1:0] taken_cnt;

    branch_seq_ctrl_if #(.XLEN(XLEN)) bus ();

    branch_seq_ctrl #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .clr_cnt      (clr_cnt),
        .resolved_cnt (resolved_cnt),
        .taken_cnt    (taken_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    res_t rq[$];
    rd_t  dq[$];
    logic [CNT_W-1:0] m_rc = '0;
    logic [CNT_W-1:0] m_tc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=absent required=present", name);
    endtask

    // Reference: condition straight from the branch definitions
    task automatic issue(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] imm, input int hold, input bit clr);
        res_t        e;
        rd_t         d;
        logic        legal;
        logic        cond;
        logic        redir;
        logic [31:0] tgt;
        int          t;
        t = 0;
        while (!bus.req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.req_ready) begin
            fail("req_ready_timeout");
            return;
        end
        legal = (f3 != 3'b010) && (f3 != 3'b011);
        cond  = 1'b0;
        case (f3)
            3'b000: cond = (rs1 == rs2);
            3'b001: cond = (rs1 != rs2);
            3'b100: cond = (longint'($signed(rs1)) <  longint'($signed(rs2)));
            3'b101: cond = (longint'($signed(rs1)) >= longint'($signed(rs2)));
            3'b110: cond = (longint'(rs1) <  longint'(rs2));
            3'b111: cond = (longint'(rs1) >= longint'(rs2));
            default: cond = 1'b0;
        endcase
        tgt = pc + imm;
        if (clr) begin
            m_rc = '0;
            m_tc = '0;
        end else if (legal) begin
            m_rc = m_rc + 1'b1;
            if (cond) m_tc = m_tc + 1'b1;
        end
        e.illegal  = !legal;
        e.taken    = legal && cond;
        e.mis      = e.taken && (tgt[1:0] != 2'b00);
        e.eval_cyc = cyc + 1;
        e.rc       = m_rc;
        e.tc       = m_tc;
        rq.push_back(e);
        redir = e.taken && !e.mis;
        if (redir) begin
            d.pc        = tgt;
            d.first_cyc = cyc + 2;
            dq.push_back(d);
        end
        bus.req_func3 = f3;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        bus.req_pc    = pc;
        bus.req_imm   = imm;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_func3 = 3'($urandom);
        bus.req_rs1   = $urandom;
        bus.req_rs2   = $urandom;
        bus.req_pc    = $urandom;
        bus.req_imm   = $urandom;
        if (clr) clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        if (!redir) begin
            chk("req_ready_back", 32'(bus.req_ready), 32'd1);
            return;
        end
        t = 0;
        while (!bus.redir_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.redir_valid) begin
            fail("redir_valid_timeout");
            return;
        end
        if (hold < 0) return;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        bus.redir_ready = 1'b1;
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (bus.redir_valid && t < 20);
        bus.redir_ready = 1'b0;
        if (bus.redir_valid) fail("redir_handshake_timeout");
    endtask

    task automatic clear_counters();
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        m_rc = '0;
        m_tc = '0;
        chk("clr_resolved", 32'(resolved_cnt), 32'd0);
        chk("clr_taken", 32'(taken_cnt), 32'd0);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations
    res_t             me;
    bit               cnt_pend = 1'b0;
    logic [CNT_W-1:0] exp_rc;
    logic [CNT_W-1:0] exp_tc;
    bit               prev_rv = 1'b0;
    bit               prev_rr = 1'b0;
    logic [31:0]      prev_pc = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt_pend = 1'b0;
            prev_rv  = 1'b0;
            prev_rr  = 1'b0;
        end else begin
            if (cnt_pend) begin
                chk("resolved_cnt", 32'(resolved_cnt), 32'(exp_rc));
                chk("taken_cnt", 32'(taken_cnt), 32'(exp_tc));
                cnt_pend = 1'b0;
            end
            if (bus.res_valid || bus.illegal || bus.misalign) begin
                if (rq.size() == 0) begin
                    fail("unexpected_result");
                end else begin
                    me = rq.pop_front();
                    chk("eval_cycle", cyc, me.eval_cyc);
                    chk("illegal", 32'(bus.illegal), 32'(me.illegal));
                    chk("res_valid", 32'(bus.res_valid), 32'(!me.illegal));
                    if (!me.illegal) chk("res_taken", 32'(bus.res_taken), 32'(me.taken));
                    chk("misalign", 32'(bus.misalign), 32'(me.mis));
                    exp_rc   = me.rc;
                    exp_tc   = me.tc;
                    cnt_pend = 1'b1;
                end
            end
            chk("flush", 32'(bus.flush), 32'(bus.redir_valid && bus.redir_ready));
            if (bus.redir_valid) begin
                if (dq.size() == 0) begin
                    fail("unexpected_redirect");
                end else begin
                    if (!prev_rv) chk("redir_start_cycle", cyc, dq[0].first_cyc);
                    else if (!prev_rr) chk("redir_pc_stable", bus.redir_pc, prev_pc);
                    chk("redir_pc", bus.redir_pc, dq[0].pc);
                    if (bus.redir_ready) void'(dq.pop_front());
                end
            end
            prev_rv = bus.redir_valid;
            prev_rr = bus.redir_ready;
            prev_pc = bus.redir_pc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, pc, imm;
        bus.req_valid   = 1'b0;
        bus.req_func3   = 3'b000;
        bus.req_rs1     = '0;
        bus.req_rs2     = '0;
        bus.req_pc      = '0;
        bus.req_imm     = '0;
        bus.redir_ready = 1'b0;

        #12;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_redir_valid", 32'(bus.redir_valid), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_redir_pc", bus.redir_pc, 32'd0);
        chk("rst_resolved", 32'(resolved_cnt), 32'd0);
        chk("rst_taken", 32'(taken_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Reset while a redirect is pending
        issue(F3_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, -1, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("pending_redir_pc", bus.redir_pc, 32'h120);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_redir_valid", 32'(bus.redir_valid), 32'd0);
        chk("mid_rst_resolved", 32'(resolved_cnt), 32'd0);
        chk("mid_rst_taken", 32'(taken_cnt), 32'd0);
        rq.delete();
        dq.delete();
        m_rc = '0;
        m_tc = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Signed vs unsigned on the same operands
        issue(F3_BLT,  32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 0, 1'b0);
        issue(F3_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 0, 1'b0);
        // Negative immediate with fetch back-pressure
        issue(F3_BNE, 32'd1, 32'd2, 32'h200, 32'hFFFF_FFF0, 3, 1'b0);
        // Misaligned taken target
        clear_counters();
        issue(F3_BGE, 32'd0, 32'd0, 32'h0, 32'h6, 0, 1'b0);
        chk("mis_resolved", 32'(resolved_cnt), 32'd1);
        chk("mis_taken", 32'(taken_cnt), 32'd1);
        chk("mis_no_redir", 32'(bus.redir_valid), 32'd0);
        // Unsupported encodings
        issue(3'b010, 32'd7, 32'd7, 32'h40, 32'h8, 0, 1'b0);
        issue(3'b011, 32'd3, 32'd9, 32'h40, 32'h8, 0, 1'b0);
        // Counter wrap: sixteen taken branches on a 4-bit counter
        clear_counters();
        for (int i = 0; i < 16; i++) begin
            issue(F3_BEQ, 32'(i), 32'(i), 32'h1000, 32'(4 * i), 0, 1'b0);
        end
        chk("wrap_resolved", 32'(resolved_cnt), 32'd0);
        chk("wrap_taken", 32'(taken_cnt), 32'd0);
        // Clear coincident with an increment
        issue(F3_BEQ, 32'd1, 32'd1, 32'h20, 32'h4, 0, 1'b0);
        issue(F3_BEQ, 32'd2, 32'd2, 32'h20, 32'h4, 1, 1'b1);
        chk("clr_win_resolved", 32'(resolved_cnt), 32'd0);
        chk("clr_win_taken", 32'(taken_cnt), 32'd0);

        for (int n = 0; n < 80; n++) begin
            f3  = 3'($urandom_range(0, 7));
            rs1 = $urandom;
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
            if ($urandom_range(0, 2) == 0) rs2 = {{24{rs1[7]}}, 8'($urandom)};
            pc  = $urandom & 32'hFFFF_FFFC;
            imm = $urandom;
            if ($urandom_range(0, 1) == 1) imm = {{20{imm[11]}}, imm[11:0]};
            if ($urandom_range(0, 2) != 0) imm[1:0] = 2'b00;
            issue(f3, rs1, rs2, pc, imm, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("result_queue_drained", rq.size(), 32'd0);
        chk("redir_queue_drained", dq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_seq_ctrl.md
# branch_seq_ctrl

Sequencer for conditional branch resolution in the multi-cycle core.
- Accepts one branch at a time from decode through a valid/ready handshake and registers its operands.
- Evaluates the branch condition and the target address, then issues a PC redirect plus a flush pulse to fetch when the branch is taken.
- Keeps wrap-around resolved and taken counters for performance monitoring.

## Interface
Parameters:
- XLEN, 32, datapath and address width
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  core clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  decode presents a branch
- req_ready  out  1  sequencer can accept a branch
- req_func3  in  3  branch type (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111)
- req_rs1, req_rs2  in  XLEN  source operands
- req_pc  in  XLEN  PC of the branch
- req_imm  in  XLEN  sign-extended B-immediate
- res_valid  out  1  one-cycle pulse: branch resolved
- res_taken  out  1  condition outcome; meaningful only while res_valid=1
- misalign  out  1  one-cycle pulse: taken target with target[1:0]≠00
- illegal  out  1  one-cycle pulse: unsupported func3 (010, 011)
- redir_valid  out  1  redirect request to fetch
- redir_ready  in  1  fetch accepts the redirect
- redir_pc  out  XLEN  redirect target
- flush  out  1  one-cycle pulse on the redirect handshake
- clr_cnt  in  1  synchronous clear of both counters
- resolved_cnt, taken_cnt  out  CNT_W  performance counters

## Operation
- The FSM has three states: IDLE, EVAL, REDIR.
- **IDLE**
  - req_ready=1.
  - On req_valid&&req_ready, capture func3, rs1, rs2, pc and imm, then go to EVAL.
  - Request inputs are ignored in every other cycle.
- **EVAL**
  - req_ready=0.
  - Condition from the captured operands:
    - BEQ/BNE compare for equality.
    - BLT/BGE compare two's-complement signed.
    - BLTU/BGEU compare unsigned.
  - target = pc + imm, truncated to XLEN; overflow wraps.
  - func3 illegal: illegal=1, res_valid=0, no counter update, next state IDLE.
  - Otherwise: res_valid=1, res_taken=cond, resolved_cnt increments.
  - If cond=1, taken_cnt also increments.
  - cond=1 and target[1:0]≠00: misalign=1, no redirect, next state IDLE.
  - cond=1 and target aligned: load redir_pc←target, next state REDIR.
  - cond=0: next state IDLE.
- **REDIR**
  - redir_valid=1.
  - redir_pc stays stable until redir_ready=1.
  - On the handshake cycle: flush=1, next state IDLE.
- Counters
  - Wrap modulo 2^CNT_W.
  - clr_cnt has priority over an increment in the same cycle; the result is 0.
- Reset
  - rst_n low at any time forces IDLE and drops any captured or pending redirect.
  - Reset values: req_ready=0 while reset is held and 1 after release; every other output and both counters 0.

## Timing
- Accept at edge N. EVAL occupies cycle N+1; res_valid, res_taken, misalign and illegal are combinational from state and registers during that cycle.
- redir_valid is asserted from cycle N+2.
- flush is asserted in the cycle with redir_valid&&redir_ready, combinationally from redir_ready.
- Throughput:
  - Not-taken, illegal or misaligned: one branch per 2 cycles.
  - Taken: 3 cycles plus fetch back-pressure.
- No combinational path from req_* to any output; req_ready depends on state only.
- redir_valid, once asserted, stays asserted with unchanged redir_pc until the handshake.

## Structure
- Package branch_pkg holds:
  - func3 localparams F3_BEQ … F3_BGEU
  - state enum {IDLE, EVAL, REDIR}
  - helper function func3_legal()
- Sub-module branch_compare is combinational: rs1, rs2, func3 → cond, with signed/unsigned selection. It is instantiated once in the EVAL path.
- Remaining logic lives in the top: FSM, operand registers, target adder, counters.

## Test plan
- Reset mid-REDIR: BEQ rs1=rs2=5, pc=0x100, imm=0x20, hold redir_ready=0, pulse rst_n low → redir_valid=0, counters=0, req_ready=1 after release.
- BLT rs1=0xFFFFFFFF (-1), rs2=1 → res_taken=1, redir_pc=pc+imm. BLTU with the same operands → res_taken=0, no redirect.
- BNE taken, pc=0x200, imm=0xFFFFFFF0, redir_ready low for 3 cycles → redir_pc=0x1F0 stable throughout, exactly one flush pulse on the handshake cycle.
- BGE taken, pc=0x0, imm=0x6 → misalign pulse, no redir_valid, resolved_cnt=1, taken_cnt=1.
- func3=010 → illegal pulse, res_valid=0, counters unchanged, back to IDLE after 2 cycles.
- Counter wrap and clear:
  - CNT_W=4, 16 taken BEQs → resolved_cnt=0 and taken_cnt=0.
  - clr_cnt asserted coincident with an EVAL increment → both counters 0.
